// File: rtl/wb_burst_sram.sv
// Wishbone responder over a byte-enabled synchronous RAM with 4-beat line bursts.
// Optional macro WBSRAM_PREFETCH_EN: burst reads prefetch the next word for 1 cycle/beat.
`timescale 1ns/1ps

`ifndef WB_ADDR_W
`define WB_ADDR_W 24
`endif
`ifndef RW
`define RW 16
`endif

module wb_burst_sram #(
    parameter int unsigned MEM_AW    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  wb_cyc,
    input  logic                  wb_stb,
    input  logic                  wb_we,
    input  logic [`WB_ADDR_W-1:0] wb_adr,
    input  logic [`RW-1:0]        wb_i_dat,
    output logic [`RW-1:0]        wb_o_dat,
    input  logic [1:0]            wb_sel,
    input  logic                  wb_4_burst,
    output logic                  wb_ack,
    output logic                  wb_err
);

    localparam int unsigned AW    = `WB_ADDR_W;
    localparam int unsigned DW    = `RW;
    localparam int unsigned TAG_W = AW - MEM_AW;
    localparam int unsigned DEPTH = 32'(1) << MEM_AW;
`ifdef WBSRAM_PREFETCH_EN
    localparam bit PREFETCH = 1'b1;
`else
    localparam bit PREFETCH = 1'b0;
`endif

    typedef enum logic {S_IDLE, S_RESP} state_t;

    state_t          state;
    logic [1:0]      cnt;
    logic [AW-1:0]   pend_addr;
    logic            pend_we;

    logic [DW-1:0]   mem [0:DEPTH-1];
    logic [DW-1:0]   ram_q;

    logic            req;
    logic            tag_hit;
    logic            beat_valid;
    logic            burst_more;
    logic            stay;
    logic            rd_idle;
    logic            rd_en;
    logic            wr_en;
    logic [AW-1:0]   pred_addr;
    logic [MEM_AW-1:0] rd_idx;

    // Beat qualification; reads must hit the address the RAM was primed with.
    assign req        = wb_cyc && wb_stb;
    assign tag_hit    = (wb_adr[AW-1:MEM_AW] == TAG_W'(BASE_ADDR));
    assign beat_valid = (state == S_RESP) && req && (wb_we == pend_we)
                        && (pend_we || (wb_adr == pend_addr));
    assign burst_more = wb_4_burst && (cnt != 2'd3);
    assign stay       = beat_valid && burst_more && (pend_we || PREFETCH);
    assign pred_addr  = {wb_adr[AW-1:2], wb_adr[1:0] + 2'd1};

    assign wb_ack   = beat_valid && tag_hit;
    assign wb_err   = beat_valid && !tag_hit;
    assign wb_o_dat = ((state == S_RESP) && !pend_we) ? ram_q : '0;

    assign rd_idle = (state == S_IDLE) && req && !wb_we && tag_hit;
    assign rd_en   = rd_idle || (stay && !pend_we && tag_hit);
    assign rd_idx  = rd_idle ? wb_adr[MEM_AW-1:0] : pred_addr[MEM_AW-1:0];
    assign wr_en   = wb_ack && pend_we;

    // Control FSM: counter and pending beat info.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S_IDLE;
            cnt       <= 2'd0;
            pend_addr <= '0;
            pend_we   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= 2'd0;
                    if (req) begin
                        pend_addr <= wb_adr;
                        pend_we   <= wb_we;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (stay) begin
                        cnt <= cnt + 2'd1;
                        if (!pend_we) begin
                            pend_addr <= pred_addr;
                        end
                    end else begin
                        cnt   <= 2'd0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    cnt   <= 2'd0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Storage array; not reset, writes only on an acked write beat.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            for (int b = 0; b < 2; b++) begin
                if (wb_sel[b]) begin
                    mem[wb_adr[MEM_AW-1:0]][b*8 +: 8] <= wb_i_dat[b*8 +: 8];
                end
            end
        end
        if (rd_en) begin
            ram_q <= mem[rd_idx];
        end
    end

endmodule
